// File: rtl/fpnew_hub_slice_arbiter.sv
// Round-robin arbiter that merges per-format slice results into a small output FIFO.
// Upstream ready depends only on occupancy, flush and reset, so a full buffer blocks input even when popped.
module fpnew_hub_slice_arbiter #(
    parameter int unsigned NumSlices = 4,
    parameter int unsigned Width     = 32,
    parameter int unsigned TagWidth  = 1,
    parameter int unsigned Depth     = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumSlices-1:0][Width-1:0]     slice_result_i,
    input  logic [NumSlices-1:0][4:0]           slice_status_i,
    input  logic [NumSlices-1:0]                slice_ext_bit_i,
    input  logic [NumSlices-1:0][TagWidth-1:0]  slice_tag_i,
    input  logic [NumSlices-1:0]                slice_valid_i,
    output logic [NumSlices-1:0]                slice_ready_o,
    input  logic                                flush_i,
    output logic [Width-1:0]                    result_o,
    output logic [4:0]                          status_o,
    output logic                                extension_bit_o,
    output logic [TagWidth-1:0]                 tag_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic                                busy_o
);

    localparam int unsigned PtrW  = $clog2(NumSlices);
    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);

    typedef struct packed {
        logic [Width-1:0]    result;
        logic [4:0]          status;
        logic                ext;
        logic [TagWidth-1:0] tag;
    } entry_t;

    entry_t            mem [Depth];
    logic [AddrW-1:0]  rd_ptr;
    logic [AddrW-1:0]  wr_ptr;
    logic [CntW-1:0]   count;
    logic [PtrW-1:0]   rr_ptr;
    logic [PtrW-1:0]   sel_idx;
    logic [PtrW-1:0]   cand;
    logic              sel_found;
    logic              can_accept;
    logic              push;
    logic              pop;
    int unsigned       idx;

    // Search upward from the round-robin pointer, wrapping at NumSlices.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NumSlices; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NumSlices) begin
                idx = idx - NumSlices;
            end
            cand = PtrW'(idx);
            if (!sel_found && slice_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign can_accept    = !rst_i && !flush_i && (count < CntW'(Depth));
    assign push          = sel_found && can_accept;
    assign slice_ready_o = push ? (NumSlices'(1) << sel_idx) : '0;
    assign out_valid_o   = (count != '0);
    assign pop           = out_valid_o && out_ready_i;
    assign busy_o        = out_valid_o || (|slice_valid_i);

    assign result_o        = mem[rd_ptr].result;
    assign status_o        = mem[rd_ptr].status;
    assign extension_bit_o = mem[rd_ptr].ext;
    assign tag_o           = mem[rd_ptr].tag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            rr_ptr <= '0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AddrW'(1);
                rr_ptr <= (sel_idx == PtrW'(NumSlices - 1)) ? '0 : sel_idx + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AddrW'(1);
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (!push && pop) begin
                count <= count - CntW'(1);
            end
        end
    end

    // Buffer storage is deliberately left out of reset; occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{result: slice_result_i[sel_idx],
                             status: slice_status_i[sel_idx],
                             ext:    slice_ext_bit_i[sel_idx],
                             tag:    slice_tag_i[sel_idx]};
        end
    end

endmodule

// File: tb/tb_fpnew_hub_slice_arbiter.sv
// Bench for fpnew_hub_slice_arbiter: hand-derived cycle table followed by random traffic against a queue model.
module tb_fpnew_hub_slice_arbiter;

    localparam int NS = 4;
    localparam int W  = 32;
    localparam int TW = 1;
    localparam int D  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NS-1:0][W-1:0]     slice_result;
    logic [NS-1:0][4:0]       slice_status;
    logic [NS-1:0]            slice_ext_bit;
    logic [NS-1:0][TW-1:0]    slice_tag;
    logic [NS-1:0]            slice_valid;
    logic [NS-1:0]            slice_ready;
    logic                     flush;
    logic [W-1:0]             result;
    logic [4:0]               status;
    logic                     extension_bit;
    logic [TW-1:0]            tag;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    fpnew_hub_slice_arbiter #(
        .NumSlices (NS),
        .Width     (W),
        .TagWidth  (TW),
        .Depth     (D)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .slice_result_i  (slice_result),
        .slice_status_i  (slice_status),
        .slice_ext_bit_i (slice_ext_bit),
        .slice_tag_i     (slice_tag),
        .slice_valid_i   (slice_valid),
        .slice_ready_o   (slice_ready),
        .flush_i         (flush),
        .result_o        (result),
        .status_o        (status),
        .extension_bit_o (extension_bit),
        .tag_o           (tag),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  result;
        logic [4:0]    status;
        logic          ext;
        logic [TW-1:0] tag;
    } entry_t;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       ordy;
        logic       flush;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic       exp_busy;
        int         head;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] res_of(input int k);
        return (k == 2) ? 32'h3F80_0000 : 32'hA000_0000 + 32'(k);
    endfunction
    function automatic logic [4:0] st_of(input int k);
        return 5'(k * 5 + 1);
    endfunction

    task automatic drive_fixed_data();
        for (int k = 0; k < NS; k++) begin
            slice_result[k]  = res_of(k);
            slice_status[k]  = st_of(k);
            slice_ext_bit[k] = (k % 2 == 1);
            slice_tag[k]     = (k % 2 == 0) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic check_head(input string pfx, input entry_t e);
        check({pfx, "_result"}, 64'(result), 64'(e.result));
        check({pfx, "_status"}, 64'(status), 64'(e.status));
        check({pfx, "_ext"},    64'(extension_bit), 64'(e.ext));
        check({pfx, "_tag"},    64'(tag), 64'(e.tag));
    endtask

    vec_t   tbl[$];
    entry_t q[$];
    entry_t e;
    int     rr;
    int     sel;
    logic [3:0] exp_ready;
    logic       exp_ov;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; slice_valid = '0;
        drive_fixed_data();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ready", 64'(slice_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        //              rst valid    ordy flush ready    ov  busy head
        tbl.push_back('{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, -1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1,  2});
        tbl.push_back('{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, -1});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, -1});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1,  0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1,  1});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1,  2});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1,  3});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1,  0});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1,  0});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1,  0});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1,  1});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1,  1});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, -1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1,  1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, -1});
        tbl.push_back('{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, -1});
        tbl.push_back('{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1,  3});
        tbl.push_back('{1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1,  3});
        tbl.push_back('{1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1,  3});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1,  3});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, -1});
        tbl.push_back('{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1,  0});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, -1});

        rst = 1'b0;
        foreach (tbl[r]) begin
            rst = tbl[r].rst; slice_valid = tbl[r].valid;
            out_ready = tbl[r].ordy; flush = tbl[r].flush;
            #1;
            check($sformatf("tbl%0d_ready", r), 64'(slice_ready), 64'(tbl[r].exp_ready));
            check($sformatf("tbl%0d_out_valid", r), 64'(out_valid), 64'(tbl[r].exp_ov));
            check($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].exp_busy));
            if (tbl[r].head >= 0) begin
                e.result = res_of(tbl[r].head);
                e.status = st_of(tbl[r].head);
                e.ext    = (tbl[r].head % 2 == 1);
                e.tag    = (tbl[r].head % 2 == 0) ? 1'b1 : 1'b0;
                check_head($sformatf("tbl%0d", r), e);
            end
            @(negedge clk);
        end

        // Random traffic: model is a FIFO queue plus an integer round-robin pointer.
        rst = 1'b1; flush = 1'b0; slice_valid = '0;
        @(negedge clk);
        q.delete(); rr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst         = ($urandom_range(0, 59) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            slice_valid = 4'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NS; k++) begin
                slice_result[k]  = $urandom;
                slice_status[k]  = 5'($urandom);
                slice_ext_bit[k] = 1'($urandom);
                slice_tag[k]     = TW'($urandom);
            end
            #1;
            sel = -1;
            for (int i = 0; i < NS; i++) begin
                if (sel < 0 && slice_valid[(rr + i) % NS]) sel = (rr + i) % NS;
            end
            exp_ready = (!rst && !flush && q.size() < D && sel >= 0) ? 4'(1 << sel) : 4'b0000;
            exp_ov    = (q.size() != 0);
            check("rnd_ready", 64'(slice_ready), 64'(exp_ready));
            check("rnd_out_valid", 64'(out_valid), 64'(exp_ov));
            check("rnd_busy", 64'(busy), 64'(exp_ov || (slice_valid != 0)));
            if (exp_ov) check_head("rnd", q[0]);
            if (rst) begin
                q.delete(); rr = 0;
            end else if (flush) begin
                q.delete();
            end else begin
                if (exp_ov && out_ready) void'(q.pop_front());
                if (exp_ready != 0) begin
                    e.result = slice_result[sel];
                    e.status = slice_status[sel];
                    e.ext    = slice_ext_bit[sel];
                    e.tag    = slice_tag[sel];
                    q.push_back(e);
                    rr = (sel + 1) % NS;
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
